// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: lc3b control/data bundle types and the NOP control word for stage registers
package pipe_stage_reg_pkg;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_pad;
  } lc3b_control_word_mem;
  typedef struct packed {
    logic regfile_mem;
    logic load_regfile;
    logic load_cc;
    logic wb_pad;
  } lc3b_control_word_wb;
  typedef logic [7:0] lc3b_ctrl_t;
  localparam lc3b_ctrl_t CTRL_NOP = '0;
  typedef struct packed {
    logic [2:0]  dest;
    logic [15:0] pc;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [12:0] offset;
  } lc3b_exmem_data_t;
  function automatic lc3b_ctrl_t pack_ctrl(input lc3b_control_word_mem mem, input lc3b_control_word_wb wb);
    return {mem, wb};
  endfunction
endpackage

// File: rtl/pipe_stage_reg_skid_slot.sv
// pipe_skid_slot: one beat holding register (valid flag + ctrl/data) with load and clear
module pipe_skid_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  // load wins over clear so a simultaneous emit+accept keeps the pipe full
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage register with flush, gated ctrl and saturating stall counter; SKID_EN adds a skid slot with registered in_ready
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              m_valid, emit, accept, m_load, m_clear;
  logic [CTRL_W-1:0] m_ctrl, m_in_ctrl;
  logic [DATA_W-1:0] m_in_data;
  assign emit = m_valid & out_ready;
  assign m_clear = flush | emit;
`ifdef SKID_EN
  logic              s_valid, s_load, s_clear, s_valid_next, ready_q;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  assign in_ready = ready_q;
  assign accept = in_valid & ready_q & ~flush;
  assign m_load = ~flush & ((emit & s_valid) | (accept & (~m_valid | emit)));
  assign m_in_ctrl = s_valid ? s_ctrl : in_ctrl;
  assign m_in_data = s_valid ? s_data : in_data;
  assign s_load = accept & m_valid & ~out_ready;
  assign s_clear = flush | emit;
  assign s_valid_next = s_load | (s_valid & ~s_clear);
  // in_ready is registered from next skid occupancy, breaking the out_ready->in_ready path
  always_ff @(posedge clk) begin
    if (reset) ready_q <= 1'b0;
    else ready_q <= ~s_valid_next;
  end
  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk(clk), .reset(reset), .load(s_load), .clear(s_clear),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .valid(s_valid), .ctrl(s_ctrl), .data(s_data)
  );
`else
  assign in_ready = ~m_valid | out_ready | flush;
  assign accept = in_valid & in_ready & ~flush;
  assign m_load = accept;
  assign m_in_ctrl = in_ctrl;
  assign m_in_data = in_data;
`endif
  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk(clk), .reset(reset), .load(m_load), .clear(m_clear),
    .in_ctrl(m_in_ctrl), .in_data(m_in_data),
    .valid(m_valid), .ctrl(m_ctrl), .data(out_data)
  );
  assign out_valid = m_valid;
  assign out_ctrl = m_valid ? m_ctrl : CTRL_W'(CTRL_NOP);
  // count stalled cycles, sticking at all-ones
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (m_valid & ~out_ready & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue model (SKID_EN selects skid expectations)
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [3:0]  stall_cnt;
  int checks = 0;
  int fails = 0;
  typedef struct {logic [7:0] c; logic [63:0] d;} beat_t;
  beat_t       q[$];
  logic [63:0] seen[$];
  logic [63:0] exp_seen[$];
  int          cnt;
  bit          rdy_m;
  logic [63:0] last_d;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always @(posedge clk) if (!reset && out_valid && out_ready) seen.push_back(out_data);

  function automatic bit exp_ready();
`ifdef SKID_EN
    return rdy_m;
`else
    return q.size() == 0 || out_ready || flush;
`endif
  endfunction
  function automatic bit exp_valid();
    return q.size() != 0;
  endfunction
  function automatic logic [7:0] exp_ctrl();
    return q.size() != 0 ? q[0].c : 8'h00;
  endfunction
  function automatic logic [63:0] exp_data();
    return q.size() != 0 ? q[0].d : last_d;
  endfunction

  task automatic tick();
    bit r;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cnt = 0;
      rdy_m = 0;
      last_d = '0;
    end else begin
      r = exp_ready();
      if (q.size() != 0 && !out_ready && !flush && cnt < 15) cnt++;
      if (q.size() != 0 && out_ready) begin
        exp_seen.push_back(q[0].d);
        void'(q.pop_front());
      end
      if (in_valid && r && !flush) q.push_back('{in_ctrl, in_data});
      if (flush) q.delete();
      rdy_m = q.size() < 2;
      if (q.size() != 0) last_d = q[0].d;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input logic [63:0] d, input bit ordy, input bit fl);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 8'h00, 64'h0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    seen.delete();
    exp_seen.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 8'hA5, 64'hDEAD, 1, 0);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin fails++; $display("FAIL reset_ctrl got %h exp 00", out_ctrl); end
    checks++; if (stall_cnt !== 4'h0) begin fails++; $display("FAIL reset_cnt got %h exp 0", stall_cnt); end
    checks++; if (out_data !== exp_data()) begin fails++; $display("FAIL reset_data got %h exp %h", out_data, exp_data()); end
    reset = 1'b0;
    drive(0, 8'h00, 64'h0, 0, 0);
    tick();
    checks++; if (in_ready !== exp_ready()) begin fails++; $display("FAIL reset_ready got %b exp %b", in_ready, exp_ready()); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'($urandom_range(1, 255)), 64'(i), 1, 0);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 64'(i) || out_data !== exp_data() || out_ctrl !== exp_ctrl())
        begin fails++; $display("FAIL stream_beat%0d got v=%b d=%0d c=%h exp v=1 d=%0d c=%h", i, out_valid, out_data, out_ctrl, i, exp_ctrl()); end
    end
    drive(0, 8'h00, 64'h0, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin fails++; $display("FAIL stream_drain got v=%b c=%h exp v=0 c=00", out_valid, out_ctrl); end
    checks++; if (seen.size() != 4 || seen != exp_seen) begin fails++; $display("FAIL stream_order got %0d beats exp %0d", seen.size(), exp_seen.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 8'h3C, 64'h1234, 0, 0);
    tick();
    drive(0, 8'h00, 64'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_ctrl !== 8'h3C || in_ready !== exp_ready())
        begin fails++; $display("FAIL stall_hold%0d got c=%h rdy=%b exp c=3c rdy=%b", i, out_ctrl, in_ready, exp_ready()); end
      tick();
    end
    checks++; if (stall_cnt !== 4'd5 || stall_cnt !== 4'(cnt)) begin fails++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
    drive(0, 8'h00, 64'h0, 1, 0);
    tick();
    tick();
    checks++; if (seen.size() != 1 || seen != exp_seen) begin fails++; $display("FAIL stall_release got %0d emits exp 1", seen.size()); end
    checks++; if (stall_cnt !== 4'd5) begin fails++; $display("FAIL stall_cnt_hold got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 8'h11, 64'd5, 0, 0);
    tick();
    drive(1, 8'h22, 64'd9, 0, 1);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    tick();
    drive(0, 8'h00, 64'h0, 0, 0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin fails++; $display("FAIL flush_bubble got v=%b c=%h exp v=0 c=00", out_valid, out_ctrl); end
    drive(0, 8'h00, 64'h0, 1, 0);
    repeat (3) tick();
    checks++; if (seen.size() != 0) begin fails++; $display("FAIL flush_drop got %0d emits exp 0", seen.size()); end
    drive(1, 8'h33, 64'd6, 0, 0);
    tick();
    drive(0, 8'h00, 64'h0, 1, 1);
    tick();
    drive(0, 8'h00, 64'h0, 1, 0);
    tick();
    checks++; if (seen.size() != 1 || seen != exp_seen) begin fails++; $display("FAIL flush_emit got %0d emits exp %0d", seen.size(), exp_seen.size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 8'h44, 64'd7, 0, 0);
    tick();
    drive(0, 8'h00, 64'h0, 0, 0);
    repeat (20) tick();
    checks++; if (stall_cnt !== 4'hF || stall_cnt !== 4'(cnt)) begin fails++; $display("FAIL sat_cnt got %h exp f", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 64'd7) begin fails++; $display("FAIL sat_hold got v=%b d=%0d exp v=1 d=7", out_valid, out_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 8'h07, 64'd7, 0, 0);
    tick();
    drive(1, 8'h08, 64'd8, 0, 0);
    tick();
    drive(0, 8'h00, 64'h0, 0, 0);
    #1;
`ifdef SKID_EN
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
`else
    checks++; if (in_ready !== 1'b0 || out_data !== 64'd7) begin fails++; $display("FAIL b2b_stall got rdy=%b d=%0d exp rdy=0 d=7", in_ready, out_data); end
`endif
    drive(0, 8'h00, 64'h0, 1, 0);
    tick();
    checks++; if (out_valid !== exp_valid() || out_data !== exp_data() || in_ready !== exp_ready())
      begin fails++; $display("FAIL b2b_move got v=%b d=%0d rdy=%b exp v=%b d=%0d rdy=%b", out_valid, out_data, in_ready, exp_valid(), exp_data(), exp_ready()); end
`ifdef SKID_EN
    checks++; if (out_data !== 64'd8 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_skid got d=%0d rdy=%b exp d=8 rdy=1", out_data, in_ready); end
`endif
    tick();
    tick();
    checks++; if (seen != exp_seen) begin fails++; $display("FAIL b2b_order got %0d emits exp %0d", seen.size(), exp_seen.size()); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      #1;
      checks++; if (in_ready !== exp_ready()) begin fails++; bad++; $display("FAIL rand_ready cyc %0d got %b exp %b", i, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== exp_valid() || out_ctrl !== exp_ctrl() || out_data !== exp_data() || stall_cnt !== 4'(cnt))
        begin fails++; bad++; $display("FAIL rand_out cyc %0d got v=%b c=%h d=%h n=%0d exp v=%b c=%h d=%h n=%0d", i, out_valid, out_ctrl, out_data, stall_cnt, exp_valid(), exp_ctrl(), exp_data(), cnt); end
      if (bad > 10) break;
    end
    drive(0, 8'h00, 64'h0, 1, 0);
    tick();
    tick();
    tick();
    checks++; if (seen != exp_seen) begin fails++; $display("FAIL rand_stream got %0d emits exp %0d", seen.size(), exp_seen.size()); end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 64'h0, 0, 0);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
